// File: rtl/serial_word_pkg.sv
// Shared types and sizing helpers for serial_word_loader.
// Frame length depends on the PARITY_CHECK_EN macro.
package serial_word_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } swl_state_t;

  // With parity enabled, one extra serial bit trails the data bits.
  function automatic int frame_bits(input int width);
`ifdef PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Frame bit counter for serial_word_loader: counts 0..FRAME_BITS and saturates.
// last flags that the next counted bit completes the frame.
module swl_bit_counter #(
  parameter int FRAME_BITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic restart,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CNT_W'(1);
    end else if (inc && (cnt != CNT_W'(FRAME_BITS))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader feeding a WIDTH-bit load register.
// Optional even-parity trailer bit enabled by defining PARITY_CHECK_EN.
module serial_word_loader
  import serial_word_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] d_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err
);

  localparam int FRAME_BITS = frame_bits(WIDTH);
  localparam int CNT_W      = cnt_width(WIDTH);

  swl_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             start, inc, last, finish, par_ok, fail, clear;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  assign start  = sin_valid & frame_start;
  assign inc    = sin_valid & ~frame_start & (state == SHIFT);
  assign finish = inc & last;

`ifdef PARITY_CHECK_EN
  // Final bit is the parity bit; data is already complete in shreg.
  assign word   = shreg;
  assign par_ok = ~(^shreg ^ sin);
`else
  assign word   = shift_in(shreg, sin);
  assign par_ok = 1'b1;
`endif

  assign fail  = finish & ~par_ok;
  assign clear = (~start & (state != SHIFT)) | fail;

  swl_bit_counter #(
    .FRAME_BITS(FRAME_BITS),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .restart(start),
    .inc    (inc),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      d_out     <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shreg <= shift_in('0, sin);
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (start) begin
            // Mid-frame restart: drop the partial word, current bit is bit 0.
            shreg     <= shift_in('0, sin);
            frame_err <= 1'b1;
          end else if (finish) begin
            busy <= 1'b0;
            if (par_ok) begin
              d_out <= word;
              load  <= 1'b1;
              state <= DONE;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (inc) begin
            shreg <= shift_in(shreg, sin);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
